pulse_stretch_fsm: RTL and testbench

Tick-to-level converter, the inverse of the edge-detect blocks. It turns a single-cycle input tick into a clean high level of programmable length, then enforces a minimum low gap before the next pulse. Typical uses: stretching debounced or edge-detected ticks so they can drive LEDs, external strobes or slower consumers. Moore FSM with a down-counter; the output is decoded from registered state only.

---
 rtl/pulse_stretch_fsm_if.sv | 14 +
 rtl/pulse_stretch_fsm.sv | 86 ++++++++
 tb/tb_pulse_stretch_fsm.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pulse_stretch_fsm_if.sv
// Tick/level bundle for pulse_stretch_fsm: the requester drives tick and length,
// the stretcher returns the level, busy and drop flags.
interface pulse_stretch_fsm_if #(
  parameter int W = 8
);
  logic         i_tick;
  logic [W-1:0] i_len;
  logic         o_level;
  logic         o_busy;
  logic         o_drop;

  modport master (output i_tick, output i_len, input o_level, input o_busy, input o_drop);
  modport slave  (input i_tick, input i_len, output o_level, output o_busy, output o_drop);
endinterface

// File: rtl/pulse_stretch_fsm.sv
// Tick-to-level converter: stretches an accepted tick into an L-cycle high level,
// then holds a GAP-cycle low guard before the next pulse. Moore outputs only.
module pulse_stretch_fsm #(
  parameter int W      = 8,
  parameter int GAP    = 2,
  parameter int RETRIG = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  pulse_stretch_fsm_if.slave bus
);

  localparam logic [1:0]   e_idle   = 2'd0;
  localparam logic [1:0]   e_high   = 2'd1;
  localparam logic [1:0]   e_gap    = 2'd2;
  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] GAP_LOAD = W'((GAP > 0) ? GAP - 1 : 0);

  if (W < 1 || GAP < 0 || (GAP > 0 && $clog2(GAP) > W)) begin : g_bad_param
    $error("pulse_stretch_fsm: GAP-1 must fit in W bits");
  end

  logic [1:0]   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         drop_q, drop_d;
  logic [W-1:0] len_m1;

  // A zero length is stretched to one cycle, so the reload value is L-1 either way.
  assign len_m1 = (bus.i_len == '0) ? '0 : bus.i_len - ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    case (state_q)
      e_idle: begin
        if (bus.i_tick) begin
          state_d = e_high;
          cnt_d   = len_m1;
        end
      end
      e_high: begin
        if (bus.i_tick && (RETRIG != 0)) begin
          cnt_d = len_m1;
        end else begin
          drop_d = bus.i_tick;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else if (GAP > 0) begin
            state_d = e_gap;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = e_idle;
            cnt_d   = '0;
          end
        end
      end
      e_gap: begin
        drop_d = bus.i_tick;
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        else             state_d = e_idle;
      end
      default: begin
        state_d = e_idle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.o_level = (state_q == e_high);
  assign bus.o_busy  = (state_q != e_idle);
  assign bus.o_drop  = drop_q;

endmodule

// File: tb/tb_pulse_stretch_fsm.sv
// Bench for pulse_stretch_fsm: three configurations share one stimulus stream;
// a remaining-cycles model feeds a scoreboard, plus a hand-computed vector table.
module tb_pulse_stretch_fsm;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  pulse_stretch_fsm_if #(.W(8)) ifA ();
  pulse_stretch_fsm_if #(.W(8)) ifB ();
  pulse_stretch_fsm_if #(.W(8)) ifC ();

  pulse_stretch_fsm #(.W(8), .GAP(2), .RETRIG(0)) uA (.i_clk(i_clk), .i_rst(i_rst), .bus(ifA));
  pulse_stretch_fsm #(.W(8), .GAP(2), .RETRIG(1)) uB (.i_clk(i_clk), .i_rst(i_rst), .bus(ifB));
  pulse_stretch_fsm #(.W(8), .GAP(0), .RETRIG(0)) uC (.i_clk(i_clk), .i_rst(i_rst), .bus(ifC));

  typedef struct {
    bit       rst;
    bit       tick;
    bit [7:0] len;
    bit       lv;
    bit       bz;
    bit       dp;
  } vec_t;

  typedef struct {
    int dut;
    bit lv;
    bit bz;
    bit dp;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model: remaining high cycles (incl. current), remaining gap cycles, drop flag
  int gapp[3] = '{2, 2, 0};
  bit rtg[3]  = '{0, 1, 0};
  int hl[3], gl[3];
  bit md[3];

  bit al[3], ab[3], ad[3];
  int hi_cnt[3], drop_cnt[3];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_tally();
    for (int d = 0; d < 3; d++) begin
      hi_cnt[d]   = 0;
      drop_cnt[d] = 0;
    end
  endtask

  task automatic step(input bit r, input bit t, input bit [7:0] l);
    int   eff;
    exp_t e;
    eff     = (l == 0) ? 1 : int'(l);
    i_rst   = r;
    ifA.i_tick = t; ifB.i_tick = t; ifC.i_tick = t;
    ifA.i_len  = l; ifB.i_len  = l; ifC.i_len  = l;
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        hl[d] = 0; gl[d] = 0; md[d] = 1'b0;
      end else if (hl[d] > 0) begin
        if (t && rtg[d]) begin
          hl[d] = eff; md[d] = 1'b0;
        end else begin
          md[d] = t;
          hl[d] = hl[d] - 1;
          if (hl[d] == 0) gl[d] = gapp[d];
        end
      end else if (gl[d] > 0) begin
        md[d] = t;
        gl[d] = gl[d] - 1;
      end else begin
        md[d] = 1'b0;
        if (t) hl[d] = eff;
      end
      e.dut = d; e.lv = (hl[d] > 0); e.bz = (hl[d] > 0) || (gl[d] > 0); e.dp = md[d];
      sb.push_back(e);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
    al[0] = ifA.o_level; ab[0] = ifA.o_busy; ad[0] = ifA.o_drop;
    al[1] = ifB.o_level; ab[1] = ifB.o_busy; ad[1] = ifB.o_drop;
    al[2] = ifC.o_level; ab[2] = ifC.o_busy; ad[2] = ifC.o_drop;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("sb_dut%0d{lvl,busy,drop}", e.dut),
          int'({al[e.dut], ab[e.dut], ad[e.dut]}), int'({e.lv, e.bz, e.dp}));
      hi_cnt[e.dut]   += int'(al[e.dut]);
      drop_cnt[e.dut] += int'(ad[e.dut]);
    end
  endtask

  task automatic v(input bit r, input bit t, input bit [7:0] l,
                   input bit lv, input bit bz, input bit dp);
    vec_t x;
    x.rst = r; x.tick = t; x.len = l; x.lv = lv; x.bz = bz; x.dp = dp;
    tv.push_back(x);
  endtask

  initial begin
    // single tick, len 4, GAP 2 on config A
    v(1,0,0, 0,0,0);
    v(0,1,4, 1,1,0);
    for (int i = 0; i < 3; i++) v(0,0,4, 1,1,0);
    for (int i = 0; i < 2; i++) v(0,0,4, 0,1,0);
    for (int i = 0; i < 2; i++) v(0,0,4, 0,0,0);
    // len 5 with a dropped high-phase tick, a dropped gap tick, re-accept on first idle
    v(0,1,5, 1,1,0);
    v(0,0,5, 1,1,0);
    v(0,1,5, 1,1,1);
    for (int i = 0; i < 2; i++) v(0,0,5, 1,1,0);
    v(0,0,5, 0,1,0);
    v(0,1,5, 0,1,1);
    v(0,0,5, 0,0,0);
    v(0,1,5, 1,1,0);
    for (int i = 0; i < 4; i++) v(0,0,5, 1,1,0);
    for (int i = 0; i < 2; i++) v(0,0,5, 0,1,0);
    v(0,0,5, 0,0,0);

    step(1, 0, 8'd0);
    step(1, 1, 8'd7);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_dut%0d", i), int'({al[i], ab[i], ad[i]}), 0);

    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].tick, tv[i].len);
      chk($sformatf("vec%0d_A", i), int'({al[0], ab[0], ad[0]}), int'({tv[i].lv, tv[i].bz, tv[i].dp}));
    end

    // zero length -> one cycle; 255 -> 255 cycles, len changes mid-pulse ignored
    clear_tally();
    step(0, 1, 8'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'd0);
    chk("len0_hi_A", hi_cnt[0], 1);
    chk("len0_hi_C", hi_cnt[2], 1);
    clear_tally();
    step(0, 1, 8'd255);
    for (int i = 0; i < 260; i++) step(0, 0, 8'($urandom_range(0, 255)));
    chk("len255_hi_A", hi_cnt[0], 255);
    chk("len255_hi_B", hi_cnt[1], 255);

    // retrigger at high cycle 3 with len 3
    clear_tally();
    step(0, 1, 8'd5);
    step(0, 0, 8'd0);
    step(0, 0, 8'd0);
    step(0, 1, 8'd3);
    for (int i = 0; i < 12; i++) step(0, 0, 8'd0);
    chk("retrig_hi_B", hi_cnt[1], 6);
    chk("retrig_drop_B", drop_cnt[1], 0);
    chk("noretrig_hi_A", hi_cnt[0], 5);
    chk("noretrig_drop_A", drop_cnt[0], 1);

    // tick on the last high cycle
    clear_tally();
    step(0, 1, 8'd3);
    step(0, 0, 8'd0);
    step(0, 0, 8'd0);
    step(0, 1, 8'd3);
    for (int i = 0; i < 10; i++) step(0, 0, 8'd0);
    chk("lastcyc_hi_B", hi_cnt[1], 6);
    chk("lastcyc_drop_B", drop_cnt[1], 0);
    chk("lastcyc_hi_C", hi_cnt[2], 3);
    chk("lastcyc_drop_C", drop_cnt[2], 1);

    // GAP=0: re-tick at L dropped, at L+1 accepted
    clear_tally();
    step(0, 1, 8'd3);
    step(0, 0, 8'd0);
    step(0, 0, 8'd0);
    step(0, 1, 8'd3);
    step(0, 1, 8'd3);
    for (int i = 0; i < 10; i++) step(0, 0, 8'd0);
    chk("gap0_hi_C", hi_cnt[2], 6);
    chk("gap0_drop_C", drop_cnt[2], 1);
    chk("gap2_drop_A", drop_cnt[0], 2);

    // reset mid-pulse with a concurrent tick
    clear_tally();
    step(0, 1, 8'd8);
    step(0, 0, 8'd0);
    step(1, 1, 8'd8);
    chk("midrst_A", int'({al[0], ab[0], ad[0]}), 0);
    chk("midrst_B", int'({al[1], ab[1], ad[1]}), 0);
    step(0, 0, 8'd0);
    step(0, 1, 8'd8);
    for (int i = 0; i < 12; i++) step(0, 0, 8'd0);
    chk("postrst_hi_A", hi_cnt[0], 10);
    chk("postrst_hi_C", hi_cnt[2], 10);

    // random traffic against the model
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 7)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
